// File: rtl/seq_det_ctrl_if.sv
// Bundle of run-control, stimulus and result signals between a stimulus
// source (master) and the sequence-detector run controller (slave).
//
// Request semantics: start is a level request with no ready/ack. The
// controller accepts it only at a rising clk edge while idle or done; while
// a run is clearing or running, start is ignored and never queued. target
// and window need only be stable at the edge where start is accepted.
interface seq_det_ctrl_if #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
);
    logic             start;
    logic [CNT_W-1:0] target;
    logic [WIN_W-1:0] window;
    logic             a_in;
    logic             b_in;
    logic             y_in;
    logic             det_clr;
    logic             a_out;
    logic             b_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] hits;
    logic [1:0]       dbg_state;

    modport master (
        output start, target, window, a_in, b_in, y_in,
        input  det_clr, a_out, b_out, busy, done, pass, hits, dbg_state
    );

    modport slave (
        input  start, target, window, a_in, b_in, y_in,
        output det_clr, a_out, b_out, busy, done, pass, hits, dbg_state
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// Run controller for a two-input Mealy sequence detector: clears the
// detector, gates A/B to it for a programmed window, counts Y pulses and
// reports pass (target reached) or fail (window expired).
module seq_det_ctrl #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    seq_det_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [WIN_W-1:0] window_q, window_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] hits_q, hits_d;
    logic             pass_q, pass_d;
    // One bit wider than hits so target = all-ones can still be matched.
    logic [CNT_W:0]   hit_inc;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Run parameters, window counter, hit counter and result flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            target_q  <= '0;
            window_q  <= '0;
            win_cnt_q <= '0;
            hits_q    <= '0;
            pass_q    <= 1'b0;
        end else begin
            target_q  <= target_d;
            window_q  <= window_d;
            win_cnt_q <= win_cnt_d;
            hits_q    <= hits_d;
            pass_q    <= pass_d;
        end
    end

    // Next-state and datapath update; a hit reaching target beats window expiry.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        window_d  = window_q;
        win_cnt_d = win_cnt_q;
        hits_d    = hits_q;
        pass_d    = pass_q;
        hit_inc   = {1'b0, hits_q} + (CNT_W+1)'(1);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d  = S_CLEAR;
                    target_d = bus.target;
                    window_d = bus.window;
                    hits_d   = '0;
                    pass_d   = 1'b0;
                end
            end
            S_CLEAR: begin
                if (target_q == '0) begin
                    state_d = S_DONE;
                    pass_d  = 1'b1;
                end else if (window_q == '0) begin
                    state_d = S_DONE;
                    pass_d  = 1'b0;
                end else begin
                    state_d   = S_RUN;
                    win_cnt_d = window_q;
                end
            end
            S_RUN: begin
                win_cnt_d = win_cnt_q - WIN_W'(1);
                if (bus.y_in && !(&hits_q)) begin
                    hits_d = hit_inc[CNT_W-1:0];
                end
                if (bus.y_in && (hit_inc == {1'b0, target_q})) begin
                    state_d = S_DONE;
                    pass_d  = 1'b1;
                end else if (win_cnt_q == WIN_W'(1)) begin
                    state_d = S_DONE;
                    pass_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; A/B reach the detector only while running.
    always_comb begin
        bus.det_clr   = (state_q == S_CLEAR);
        bus.busy      = (state_q == S_CLEAR) || (state_q == S_RUN);
        bus.done      = (state_q == S_DONE);
        bus.a_out     = (state_q == S_RUN) && bus.a_in;
        bus.b_out     = (state_q == S_RUN) && bus.b_in;
        bus.pass      = pass_q;
        bus.hits      = hits_q;
        bus.dbg_state = state_q;
    end
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: a table of run vectors plus hand-written
// reset sequences. The bench plays the detector by driving y_in directly.
module tb_seq_det_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    seq_det_ctrl_if #(.CNT_W(8), .WIN_W(8)) bus ();

    seq_det_ctrl #(.CNT_W(8), .WIN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [7:0]  target;
        logic [7:0]  window;
        logic [15:0] y_mask;   // bit k-1 set -> Y on RUN cycle k
        bit          y_all;    // Y on every RUN cycle
        bit          hold;     // keep start high through the run
        bit          exp_pass;
        logic [7:0]  exp_hits;
        int          exp_run;  // RUN cycles before DONE
    } vec_t;

    vec_t vecs[9];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int run_cyc;
        int clr_err;
        int gate_err;
        bus.target = v.target;
        bus.window = v.window;
        bus.start  = 1'b1;
        bus.y_in   = 1'b0;
        step();
        // CLEAR cycle: Y and stimulus must be blocked, result cleared.
        bus.a_in = 1'b1;
        bus.b_in = 1'b1;
        bus.y_in = 1'b1;
        #1;
        check($sformatf("v%0d_clr_det_clr", idx), bus.det_clr, 1);
        check($sformatf("v%0d_clr_busy", idx), bus.busy, 1);
        check($sformatf("v%0d_clr_done", idx), bus.done, 0);
        check($sformatf("v%0d_clr_gate", idx), {bus.a_out, bus.b_out}, 0);
        check($sformatf("v%0d_clr_hits", idx), bus.hits, 0);
        check($sformatf("v%0d_clr_pass", idx), bus.pass, 0);
        bus.start = v.hold;
        step();
        run_cyc  = 0;
        clr_err  = 0;
        gate_err = 0;
        while (bus.busy === 1'b1 && run_cyc < 300) begin
            run_cyc++;
            bus.a_in = 1'($urandom_range(0, 1));
            bus.b_in = 1'($urandom_range(0, 1));
            if (v.y_all) bus.y_in = 1'b1;
            else if (run_cyc <= 16) bus.y_in = v.y_mask[run_cyc-1];
            else bus.y_in = 1'b0;
            #1;
            if (bus.det_clr !== 1'b0) clr_err++;
            if (bus.a_out !== bus.a_in || bus.b_out !== bus.b_in) gate_err++;
            step();
        end
        bus.start = 1'b0;
        bus.y_in  = 1'b0;
        bus.a_in  = 1'b1;
        bus.b_in  = 1'b1;
        #1;
        check($sformatf("v%0d_run_len", idx), run_cyc, v.exp_run);
        check($sformatf("v%0d_run_clr", idx), clr_err, 0);
        check($sformatf("v%0d_run_gate", idx), gate_err, 0);
        check($sformatf("v%0d_busy", idx), bus.busy, 0);
        check($sformatf("v%0d_done", idx), bus.done, 1);
        check($sformatf("v%0d_pass", idx), bus.pass, v.exp_pass);
        check($sformatf("v%0d_hits", idx), bus.hits, v.exp_hits);
        check($sformatf("v%0d_done_gate", idx), {bus.a_out, bus.b_out, bus.det_clr}, 0);
        step();
        check($sformatf("v%0d_hold_done", idx), bus.done, 1);
        check($sformatf("v%0d_hold_pass", idx), bus.pass, v.exp_pass);
        check($sformatf("v%0d_hold_hits", idx), bus.hits, v.exp_hits);
    endtask

    initial begin
        //          target window  y_mask    all hold pass hits  run
        vecs[0] = '{8'd2,   8'd10,  16'h0024, 0,  0,   1,   8'd2,   6};
        vecs[1] = '{8'd3,   8'd5,   16'h0002, 0,  0,   0,   8'd1,   5};
        vecs[2] = '{8'd2,   8'd4,   16'h0009, 0,  0,   1,   8'd2,   4};
        vecs[3] = '{8'd0,   8'd5,   16'h0000, 0,  0,   1,   8'd0,   0};
        vecs[4] = '{8'd1,   8'd0,   16'h0000, 0,  0,   0,   8'd0,   0};
        vecs[5] = '{8'd2,   8'd10,  16'h0024, 0,  1,   1,   8'd2,   6};
        vecs[6] = '{8'd1,   8'd1,   16'h0001, 0,  0,   1,   8'd1,   1};
        vecs[7] = '{8'd1,   8'd3,   16'h0000, 0,  0,   0,   8'd0,   3};
        vecs[8] = '{8'd255, 8'd255, 16'h0000, 1,  0,   1,   8'd255, 255};

        bus.start  = 1'b1;
        bus.target = 8'd5;
        bus.window = 8'd5;
        bus.a_in   = 1'b1;
        bus.b_in   = 1'b1;
        bus.y_in   = 1'b1;

        // Reset held with start high: controller stays idle with quiet outputs.
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("rst%0d_state", i), bus.dbg_state, 0);
            check($sformatf("rst%0d_det_clr", i), bus.det_clr, 0);
            check($sformatf("rst%0d_outs", i),
                  {bus.busy, bus.done, bus.pass, bus.a_out, bus.b_out}, 0);
            check($sformatf("rst%0d_hits", i), bus.hits, 0);
        end
        rst       = 1'b1;
        bus.start = 1'b0;
        step();
        check("idle_state", bus.dbg_state, 0);
        check("idle_busy_done", {bus.busy, bus.done, bus.det_clr}, 0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in the middle of a run aborts it.
        bus.target = 8'd3;
        bus.window = 8'd10;
        bus.start  = 1'b1;
        bus.y_in   = 1'b0;
        step();
        bus.start = 1'b0;
        step();
        bus.y_in = 1'b1;
        step();
        bus.y_in = 1'b0;
        step();
        check("mid_busy", bus.busy, 1);
        check("mid_hits", bus.hits, 1);
        rst      = 1'b0;
        bus.a_in = 1'b1;
        bus.b_in = 1'b1;
        step();
        check("abort_state", bus.dbg_state, 0);
        check("abort_outs", {bus.busy, bus.done, bus.pass, bus.det_clr, bus.a_out, bus.b_out}, 0);
        check("abort_hits", bus.hits, 0);
        rst = 1'b1;
        step();
        check("abort_idle", {bus.busy, bus.done}, 0);
        run_vec('{8'd1, 8'd2, 16'h0002, 0, 0, 1, 8'd1, 2}, 9);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Run controller for the two-input Mealy sequence detector (inputs A/B, output Y).
- On a start request it clears the detector and gates A/B through to it for a programmed window of cycles.
- It counts Y pulses and reports pass (target reached) or fail (window expired).
- Sits between the stimulus source and the detector instance; the detector's async clear is driven from det_clr.

Parameters:
CNT_W, 8, width of target and hit counter
WIN_W, 8, width of window length / window counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-low (rst=0 at a rising clk edge resets the block)
start  input  1  run request, sampled in IDLE or DONE only
target  input  CNT_W  required number of Y pulses, latched on accepted start
window  input  WIN_W  run length in cycles, latched on accepted start
a_in  input  1  stimulus A from source
b_in  input  1  stimulus B from source
y_in  input  1  detector Y output (combinational Mealy output)
det_clr  output  1  clear to detector, high for exactly one cycle per run
a_out  output  1  A to detector: a_in in RUN, else 0
b_out  output  1  B to detector: b_in in RUN, else 0
busy  output  1  high in CLEAR and RUN
done  output  1  high while in DONE
pass  output  1  result, valid while done=1
hits  output  CNT_W  Y pulses counted in current/last run

Behaviour:
- Reset (rst=0 at edge): state=IDLE; det_clr=0, busy=0, done=0, pass=0, hits=0; latched target/window=0. Applies from any state, including mid-RUN (the run is aborted, no result).
- States: IDLE, CLEAR, RUN, DONE. Registered FSM. det_clr, busy and done decode from state. a_out/b_out are combinational gates.
- IDLE: start=1 at edge -> CLEAR; latch target and window; hits<=0; pass<=0.
- CLEAR, always 1 cycle: det_clr=1.
  - target==0 -> DONE with pass<=1.
  - else window==0 -> DONE with pass<=0.
  - else -> RUN with win_cnt<=window.
- RUN:
  - a_out=a_in, b_out=b_in.
  - Each edge: if y_in=1, hits<=hits+1, saturating at all-ones. win_cnt<=win_cnt-1.
  - If y_in=1 and hits+1==target -> DONE, pass<=1. This has priority over window expiry, so a hit on the last window cycle passes.
  - Else if win_cnt==1 -> DONE, pass<=0.
  - RUN lasts at most `window` cycles.
- DONE: done=1; pass and hits hold.
  - start=1 -> CLEAR, with the same latching as IDLE. This restart clears hits/pass.
  - There is no auto-return to IDLE.
- start in CLEAR or RUN is ignored; no queuing.
- Outside RUN, a_out=b_out=0, so the detector sees no stimulus while idle/cleared.
- y_in is ignored outside RUN.
- Latency:
  - start sampled at edge t -> det_clr high in cycle t..t+1.
  - First gated stimulus cycle is t+1..t+2.
  - done rises at the edge after the terminating RUN cycle.
- Arithmetic: all counters unsigned. hits+1 is compared at CNT_W+1 bits, so target=all-ones is reachable.

Test Plan:
1. rst=0 for 2 edges with start=1 -> state IDLE, all outputs 0, det_clr never asserted; release rst, start=0 -> remains IDLE.
2. target=2, window=10; drive A/B so the detector emits Y on RUN cycles 3 and 6.
   - Expect det_clr pulse of 1 cycle and busy for 1+6 cycles.
   - Then done=1, pass=1, hits=2.
   - a_out/b_out are 0 before and after RUN.
3. target=3, window=5, only 1 Y pulse -> exactly 5 RUN cycles, then done=1, pass=0, hits=1.
4. Boundary cases:
   - target=2, window=4, second Y on RUN cycle 4 (the last) -> pass=1.
   - target=0 -> DONE directly after CLEAR with pass=1, hits=0.
   - window=0, target=1 -> DONE after CLEAR with pass=0.
5. Start handling:
   - start asserted throughout RUN -> no restart; result as if start were a single pulse.
   - In DONE, pulse start -> new CLEAR, hits reset to 0, pass cleared.
6. rst=0 at RUN cycle 3 with hits=1 -> next cycle IDLE, hits=0, busy=0, done=0, a_out=0; a following start runs normally.
